// File: rtl/prbs15_descrambler.sv
// prbs15_descrambler
// ------------------
// Receive-side descrambler for the x^15 + x^14 + 1 scrambler. It acquires the
// keystream from a scrambled all-zero training stream (SEARCH), confirms the
// prediction over VERIFY_BITS consecutive bits (VERIFY), then descrambles
// payload beats (LOCKED). Beats move under a valid/ready handshake with a
// single registered output stage.
//
// Bit 0 of every beat is the earliest bit on the line, and all DW bits of an
// accepted beat are processed in the accept cycle.
//
// Build option: define PRBS15_SYNC_FAIL_CNT_EN to add the sync_fail_cnt output.
// It is a saturating count of VERIFY->SEARCH drops and SEARCH zero-state
// rejections.

module prbs15_descrambler #(
    parameter int DW          = 8,   // bits per beat, 1..16
    parameter int VERIFY_BITS = 32   // matches needed for lock, 1..255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic          resync,
    output logic          locked,
    output logic [1:0]    state_o
`ifdef PRBS15_SYNC_FAIL_CNT_EN
    ,
    output logic [7:0]    sync_fail_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Value of the match counter on the last of VERIFY_BITS consecutive matches.
    localparam logic [7:0] VFY_LAST = 8'(VERIFY_BITS - 1);
    // Value of the search counter on the 15th shifted-in bit.
    localparam logic [3:0] SRCH_LAST = 4'd14;

    // Registered state.
    state_t        r_state;
    logic [14:0]   r_lfsr;
    logic [3:0]    r_srch_cnt;
    logic [7:0]    r_vfy_cnt;
    logic [DW-1:0] r_out_data;
    logic          r_out_valid;
    logic          r_locked;
`ifdef PRBS15_SYNC_FAIL_CNT_EN
    logic [7:0]    r_fail_cnt;
`endif

    // Next-state values after walking all bits of the current beat.
    state_t        w_nxt_state;
    logic [14:0]   w_nxt_lfsr;
    logic [3:0]    w_nxt_srch_cnt;
    logic [7:0]    w_nxt_vfy_cnt;
    logic [DW-1:0] w_beat_out;
    logic          w_key;
`ifdef PRBS15_SYNC_FAIL_CNT_EN
    logic [7:0]    w_nxt_fail_cnt;
`endif

    logic          w_accept;
    logic          w_beat_locked;

    // The output stage can take a new beat when it is empty or draining now.
    assign in_ready      = !r_out_valid || out_ready;
    assign w_accept      = in_valid && in_ready;
    // Only a beat that starts in LOCKED is descrambled in full and produces output.
    assign w_beat_locked = (r_state == ST_LOCKED);

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign locked    = r_locked;
    assign state_o   = r_state;
`ifdef PRBS15_SYNC_FAIL_CNT_EN
    assign sync_fail_cnt = r_fail_cnt;
`endif

    // Bit-serial walk over one beat: state can change between bits of the same beat.
    always_comb begin
        // NOTE: every target gets a default first so no latch is inferred; the
        // loop then uses blocking updates on purpose, so each bit sees the
        // result of the bit before it inside the same cycle.
        w_nxt_state    = r_state;
        w_nxt_lfsr     = r_lfsr;
        w_nxt_srch_cnt = r_srch_cnt;
        w_nxt_vfy_cnt  = r_vfy_cnt;
        w_beat_out     = '0;
        w_key          = 1'b0;
`ifdef PRBS15_SYNC_FAIL_CNT_EN
        w_nxt_fail_cnt = r_fail_cnt;
`endif
        for (int i = 0; i < DW; i++) begin
            w_key = w_nxt_lfsr[14] ^ w_nxt_lfsr[13];
            case (w_nxt_state)
                ST_SEARCH: begin
                    // Load the raw line bit. Training data is all zero, so the
                    // line carries the keystream itself.
                    w_nxt_lfsr = {w_nxt_lfsr[13:0], in_data[i]};
                    if (w_nxt_srch_cnt == SRCH_LAST) begin
                        w_nxt_srch_cnt = '0;
                        if (w_nxt_lfsr != '0) begin
                            w_nxt_state   = ST_VERIFY;
                            w_nxt_vfy_cnt = '0;
                        end else begin
                            // The all-zero register is the LFSR lock-up state,
                            // so the window is rejected and the search restarts.
`ifdef PRBS15_SYNC_FAIL_CNT_EN
                            if (w_nxt_fail_cnt != 8'hFF) begin
                                w_nxt_fail_cnt = w_nxt_fail_cnt + 8'd1;
                            end
`endif
                        end
                    end else begin
                        w_nxt_srch_cnt = w_nxt_srch_cnt + 4'd1;
                    end
                end
                ST_VERIFY: begin
                    w_nxt_lfsr = {w_nxt_lfsr[13:0], w_key};
                    if (in_data[i] != w_key) begin
                        w_nxt_state    = ST_SEARCH;
                        w_nxt_srch_cnt = '0;
                        w_nxt_vfy_cnt  = '0;
`ifdef PRBS15_SYNC_FAIL_CNT_EN
                        if (w_nxt_fail_cnt != 8'hFF) begin
                            w_nxt_fail_cnt = w_nxt_fail_cnt + 8'd1;
                        end
`endif
                    end else if (w_nxt_vfy_cnt == VFY_LAST) begin
                        // Any remaining bits of this beat still advance the
                        // LFSR in LOCKED, but the beat produces no output.
                        w_nxt_state   = ST_LOCKED;
                        w_nxt_vfy_cnt = '0;
                    end else begin
                        w_nxt_vfy_cnt = w_nxt_vfy_cnt + 8'd1;
                    end
                end
                ST_LOCKED: begin
                    w_beat_out[i] = in_data[i] ^ w_key;
                    w_nxt_lfsr    = {w_nxt_lfsr[13:0], w_key};
                end
                default: begin
                    // Unused encoding: fall back to acquisition.
                    w_nxt_state    = ST_SEARCH;
                    w_nxt_srch_cnt = '0;
                    w_nxt_vfy_cnt  = '0;
                end
            endcase
        end
    end

    // Acquisition state, LFSR and counters; resync restarts the search but keeps the LFSR.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            r_state    <= ST_SEARCH;
            r_lfsr     <= '0;
            r_srch_cnt <= '0;
            r_vfy_cnt  <= '0;
            r_locked   <= 1'b0;
        end else if (resync) begin
            // resync wins over a beat accepted in the same cycle, and that beat is dropped.
            r_state    <= ST_SEARCH;
            r_srch_cnt <= '0;
            r_vfy_cnt  <= '0;
            r_locked   <= 1'b0;
        end else if (w_accept) begin
            r_state    <= w_nxt_state;
            r_lfsr     <= w_nxt_lfsr;
            r_srch_cnt <= w_nxt_srch_cnt;
            r_vfy_cnt  <= w_nxt_vfy_cnt;
            r_locked   <= (w_nxt_state == ST_LOCKED);
        end
    end

    // Single output register: load on a locked beat, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (resync) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= w_beat_locked;
            if (w_beat_locked) begin
                r_out_data <= w_beat_out;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef PRBS15_SYNC_FAIL_CNT_EN
    // Saturating sync-failure counter; resync leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_cnt <= '0;
        end else if (w_accept && !resync) begin
            r_fail_cnt <= w_nxt_fail_cnt;
        end
    end
`endif

endmodule
